// File: rtl/cell_scan_lookup_if.sv
// Pixel-side bus of cell_scan_lookup: raster position and pixel strobe in,
// per-pixel cell lookup results out.
// With CELL_GRID_LINES_EN defined the bus also carries grid_line.
interface cell_scan_lookup_if #(
    parameter int CW = 10,
    parameter int SW = 5
);
    logic          pix_en;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          cell_state;
    logic          in_grid;
    logic [SW-1:0] sub_x;
    logic [SW-1:0] sub_y;
`ifdef CELL_GRID_LINES_EN
    logic          grid_line;
`endif

    // Sync generator side
    modport master (
        output pix_en, hc, vc,
        input  cell_state, in_grid, sub_x, sub_y
`ifdef CELL_GRID_LINES_EN
        , input grid_line
`endif
    );

    // Lookup block side
    modport slave (
        input  pix_en, hc, vc,
        output cell_state, in_grid, sub_x, sub_y
`ifdef CELL_GRID_LINES_EN
        , output grid_line
`endif
    );
endinterface

// File: rtl/cell_scan_lookup.sv
// Maps the VGA raster position to a Game-of-Life board cell using incremental
// column/row and sub-cell counters, so the pixel path has no divide/multiply.
// Two-stage pipeline: stage 1 tracks position, stage 2 looks up the board.
// Optional macro CELL_GRID_LINES_EN adds a registered grid_line output and
// blanks cell_state on grid-line pixels.
module cell_scan_lookup #(
    parameter int H_OFFSET  = 224,
    parameter int V_OFFSET  = 35,
    parameter int CELL_SIZE = 30,
    parameter int COLS      = 16,
    parameter int ROWS      = 16,
    parameter int CW        = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COLS*ROWS-1:0] board,
    cell_scan_lookup_if.slave    bus
);
    localparam int SW   = $clog2(CELL_SIZE);
    localparam int COLW = $clog2(COLS + 1);
    localparam int ROWW = $clog2(ROWS + 1);
    localparam int IW   = $clog2(COLS * ROWS);

    localparam logic [CW:0]     H_LO    = (CW+1)'(H_OFFSET);
    localparam logic [CW:0]     H_HI    = (CW+1)'(H_OFFSET + COLS * CELL_SIZE);
    localparam logic [CW:0]     V_LO    = (CW+1)'(V_OFFSET);
    localparam logic [CW:0]     V_HI    = (CW+1)'(V_OFFSET + ROWS * CELL_SIZE);
    localparam logic [SW-1:0]   PX_LAST = SW'(CELL_SIZE - 1);
    localparam logic [COLW-1:0] COL_SAT = COLW'(COLS);
    localparam logic [ROWW-1:0] ROW_SAT = ROWW'(ROWS);

    logic [SW-1:0]   px;
    logic [SW-1:0]   py;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic            h_in;
    logic            v_in;
    logic            h_sync;
    logic            v_sync;

    logic [CW:0]     hc_x;
    logic [CW:0]     vc_x;
    logic            line_start;
    logic            frame_start;
    logic [IW-1:0]   idx;
    logic            cell_bit;

    assign hc_x        = {1'b0, bus.hc};
    assign vc_x        = {1'b0, bus.vc};
    assign line_start  = (bus.hc == CW'(H_OFFSET));
    assign frame_start = (bus.vc == CW'(V_OFFSET));
    assign idx         = IW'(row) * IW'(COLS) + IW'(col);
    assign cell_bit    = board[idx];

`ifdef CELL_GRID_LINES_EN
    localparam logic [CW:0] H_LAST = H_HI - (CW+1)'(1);
    localparam logic [CW:0] V_LAST = V_HI - (CW+1)'(1);

    logic h_last;
    logic v_last;
    logic on_line;

    assign on_line = (px == '0) || (py == '0) || h_last || v_last;
`endif

    // Stage 1: position tracking and range flags.
    // h_sync/v_sync keep a mid-frame reset from producing a bogus grid position:
    // the horizontal flag gates in_grid until the next line start, and the row
    // counters stay at 0 until the next first-grid line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            px     <= '0;
            py     <= '0;
            col    <= '0;
            row    <= '0;
            h_in   <= 1'b0;
            v_in   <= 1'b0;
            h_sync <= 1'b0;
            v_sync <= 1'b0;
`ifdef CELL_GRID_LINES_EN
            h_last <= 1'b0;
            v_last <= 1'b0;
`endif
        end else if (bus.pix_en) begin
            h_in <= (hc_x >= H_LO) && (hc_x < H_HI) && (line_start || h_sync);
            v_in <= (vc_x >= V_LO) && (vc_x < V_HI);
`ifdef CELL_GRID_LINES_EN
            h_last <= (hc_x == H_LAST);
            v_last <= (vc_x == V_LAST);
`endif
            if (line_start) begin
                h_sync <= 1'b1;
                col    <= '0;
                px     <= '0;
            end else if (px == PX_LAST) begin
                px <= '0;
                if (col != COL_SAT) begin
                    col <= col + COLW'(1);
                end
            end else begin
                px <= px + SW'(1);
            end

            if (line_start) begin
                if (frame_start) begin
                    v_sync <= 1'b1;
                    row    <= '0;
                    py     <= '0;
                end else if (v_sync) begin
                    if (py == PX_LAST) begin
                        py <= '0;
                        if (row != ROW_SAT) begin
                            row <= row + ROWW'(1);
                        end
                    end else begin
                        py <= py + SW'(1);
                    end
                end
            end
        end
    end

    // Stage 2: board lookup and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.in_grid    <= 1'b0;
            bus.cell_state <= 1'b0;
            bus.sub_x      <= '0;
            bus.sub_y      <= '0;
`ifdef CELL_GRID_LINES_EN
            bus.grid_line  <= 1'b0;
`endif
        end else if (bus.pix_en) begin
            bus.in_grid <= h_in & v_in;
            bus.sub_x   <= px;
            bus.sub_y   <= py;
`ifdef CELL_GRID_LINES_EN
            bus.grid_line  <= h_in & v_in & on_line;
            bus.cell_state <= h_in & v_in & ~on_line & cell_bit;
`else
            bus.cell_state <= h_in & v_in & cell_bit;
`endif
        end
    end
endmodule

// File: tb/tb_cell_scan_lookup.sv
// Directed bench for cell_scan_lookup (default geometry 16x16 cells of 30 px,
// grid at hc 224..703, vc 35..514). Define CELL_GRID_LINES_EN to also
// exercise grid_line.
module tb_cell_scan_lookup;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] board;

    cell_scan_lookup_if #(.CW(10), .SW(5)) bus ();

    cell_scan_lookup #(
        .H_OFFSET (224),
        .V_OFFSET (35),
        .CELL_SIZE(30),
        .COLS     (16),
        .ROWS     (16),
        .CW       (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .board(board),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int hc;
        int vc;
        int bsel;     // board bit to set; -1 none, 256 all ones
        int ein;
        int ecs;
        int chk_sub;
        int esx;
        int esy;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input int h, input int v, input logic en = 1'b1);
        bus.pix_en = en;
        bus.hc     = 10'(h);
        bus.vc     = 10'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.pix_en = 1'b1;
        bus.hc     = '0;
        bus.vc     = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_board(input int sel);
        board = '0;
        if (sel == 256) board = '1;
        else if (sel >= 0) board[sel] = 1'b1;
    endtask

    // Expected output for pixel h on line 35 when only board bit 1 is set
    task automatic check_line_pix(input string tag, input int h);
        int ein;
        int ecs;
        ein = (h >= 224 && h <= 703) ? 1 : 0;
        ecs = (h >= 254 && h <= 283) ? 1 : 0;
        check({tag, "_in_grid"}, 32'(bus.in_grid), ein);
        check({tag, "_cell"}, 32'(bus.cell_state), ecs);
        if (ein == 1) check({tag, "_sub_x"}, 32'(bus.sub_x), (h - 224) % 30);
    endtask

    initial begin
        rst_n      = 1'b0;
        board      = '0;
        bus.pix_en = 1'b0;
        bus.hc     = '0;
        bus.vc     = '0;

        //            hc   vc   bsel in cs sub sx  sy
        vecs[0]  = '{224,  35,   0, 1, 1, 1,  0,  0};
        vecs[1]  = '{224,  35,  -1, 1, 0, 1,  0,  0};
        vecs[2]  = '{223,  35,   0, 0, 0, 0,  0,  0};
        vecs[3]  = '{253,  35,   0, 1, 1, 1, 29,  0};
        vecs[4]  = '{254,  35,   1, 1, 1, 1,  0,  0};
        vecs[5]  = '{254,  35,   0, 1, 0, 1,  0,  0};
        vecs[6]  = '{283,  35,   1, 1, 1, 1, 29,  0};
        vecs[7]  = '{284,  35,   1, 1, 0, 1,  0,  0};
        vecs[8]  = '{703,  35,  15, 1, 1, 1, 29,  0};
        vecs[9]  = '{704,  35,  15, 0, 0, 0,  0,  0};
        vecs[10] = '{374, 125,  53, 1, 1, 1,  0,  0};
        vecs[11] = '{403, 154,  53, 1, 1, 1, 29, 29};
        vecs[12] = '{404, 154,  53, 1, 0, 1,  0, 29};
        vecs[13] = '{373, 154,  53, 1, 0, 1, 29, 29};
        vecs[14] = '{374, 155,  53, 1, 0, 1,  0,  0};
        vecs[15] = '{703, 514, 255, 1, 1, 1, 29, 29};
        vecs[16] = '{703, 515, 255, 0, 0, 0,  0,  0};
        vecs[17] = '{224,  34,   0, 0, 0, 0,  0,  0};
        vecs[18] = '{300, 100, 256, 1, 1, 1, 16,  5};

        // Reset state
        do_reset();
        bus.pix_en = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_grid", 32'(bus.in_grid), 0);
        check("rst_cell", 32'(bus.cell_state), 0);
        check("rst_sub_x", 32'(bus.sub_x), 0);
        check("rst_sub_y", 32'(bus.sub_y), 0);

        // Table: walk each line start from the top of the grid, then along the
        // target line; the output for the target pixel appears one filler later.
        for (int i = 0; i < 19; i++) begin
            do_reset();
            set_board(vecs[i].bsel);
            if (vecs[i].vc >= 35) begin
                for (int v = 35; v <= vecs[i].vc; v++) drive(224, v);
            end else begin
                drive(224, vecs[i].vc);
            end
            if (vecs[i].hc >= 224) begin
                for (int h = 225; h <= vecs[i].hc; h++) drive(h, vecs[i].vc);
            end else begin
                drive(vecs[i].hc, vecs[i].vc);
            end
            drive(0, 0);
            check($sformatf("v%0d_in_grid", i), 32'(bus.in_grid), vecs[i].ein);
            check($sformatf("v%0d_cell", i), 32'(bus.cell_state), vecs[i].ecs);
            if (vecs[i].chk_sub != 0) begin
                check($sformatf("v%0d_sub_x", i), 32'(bus.sub_x), vecs[i].esx);
                check($sformatf("v%0d_sub_y", i), 32'(bus.sub_y), vecs[i].esy);
            end
        end

        // Full line sweep on vc=35 with only column 1 lit
        do_reset();
        set_board(1);
        for (int h = 224; h <= 705; h++) begin
            drive(h, 35);
            if (h > 224) check_line_pix($sformatf("sweep_h%0d", h - 1), h - 1);
        end

        // Same sweep with a random pixel strobe: outputs advance only on strobes
        do_reset();
        set_board(1);
        for (int h = 224; h <= 705; h++) begin
            for (int t = 0; t < 8; t++) begin
                logic en;
                en = (t >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                drive(h, 35, en);
                if (en) begin
                    if (h > 224) check_line_pix($sformatf("strobe_h%0d", h - 1), h - 1);
                    break;
                end else if (h > 225) begin
                    check_line_pix($sformatf("hold_h%0d", h - 2), h - 2);
                end
            end
        end

        // Reset mid-frame at vc=100
        do_reset();
        board     = '0;
        board[34] = 1'b1;
        board[2]  = 1'b1;
        for (int v = 35; v <= 100; v++) drive(224, v);
        for (int h = 225; h <= 300; h++) drive(h, 100);
        check("pre_rst_in_grid", 32'(bus.in_grid), 1);
        check("pre_rst_cell", 32'(bus.cell_state), 1);
        check("pre_rst_sub_x", 32'(bus.sub_x), 15);
        check("pre_rst_sub_y", 32'(bus.sub_y), 5);
        rst_n = 1'b0;
        drive(301, 100);
        rst_n = 1'b1;
        check("mid_rst_in_grid", 32'(bus.in_grid), 0);
        check("mid_rst_cell", 32'(bus.cell_state), 0);
        check("mid_rst_sub_x", 32'(bus.sub_x), 0);
        check("mid_rst_sub_y", 32'(bus.sub_y), 0);
        for (int h = 302; h <= 310; h++) begin
            drive(h, 100);
            check($sformatf("post_rst_h%0d_in_grid", h - 1), 32'(bus.in_grid), 0);
        end
        drive(224, 101);
        check("post_rst_h310_in_grid", 32'(bus.in_grid), 0);
        drive(225, 101);
        check("resync_h224_in_grid", 32'(bus.in_grid), 1);
        check("resync_h224_cell", 32'(bus.cell_state), 0);
        check("resync_h224_sub_x", 32'(bus.sub_x), 0);
        check("resync_h224_sub_y", 32'(bus.sub_y), 0);
        for (int h = 226; h <= 301; h++) drive(h, 101);
        check("resync_h300_in_grid", 32'(bus.in_grid), 1);
        check("resync_h300_cell", 32'(bus.cell_state), 1);
        check("resync_h300_sub_x", 32'(bus.sub_x), 16);
        check("resync_h300_sub_y", 32'(bus.sub_y), 0);

`ifdef CELL_GRID_LINES_EN
        // Grid line at the left edge of column 1 on line vc=40
        do_reset();
        board = '1;
        for (int v = 35; v <= 40; v++) drive(224, v);
        for (int h = 225; h <= 255; h++) drive(h, 40);
        check("gl_h254_grid_line", 32'(bus.grid_line), 1);
        check("gl_h254_cell", 32'(bus.cell_state), 0);
        check("gl_h254_in_grid", 32'(bus.in_grid), 1);
        drive(256, 40);
        check("gl_h255_grid_line", 32'(bus.grid_line), 0);
        check("gl_h255_cell", 32'(bus.cell_state), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
